mips_mem_responder: RTL

- Memory-side responder for the single-cycle MIPS core. It owns the instruction ROM and the data RAM.
- Consumes the core's pc, memwrite, aluresult and rd2data (called writedata here). Returns instr and readdata.
- A load port preloads program and data words before execution. A small run controller gates execution, detects a halt store, and counts stores.
- Replaces the bench-driven instr/readdata stimulus in system-level runs.

---
 rtl/mips_mem_responder_pkg.sv | 17 +
 rtl/mips_mem_responder_if.sv | 37 +++
 rtl/mips_word_ram.sv | 26 ++
 rtl/mips_mem_responder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mips_mem_responder_pkg.sv
// Shared types and constants for the MIPS memory responder.
// Holds the run-controller state encoding and sizing helpers.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } resp_state_t;

    localparam int WORD_BYTES = 4;

    function automatic int idx_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/mips_mem_responder_if.sv
// Bus between the MIPS core/loader side and the memory responder.
// Master drives fetch/store/load requests; slave returns data and status.
interface mips_mem_responder_if;

    logic        load_valid;
    logic        load_ready;
    logic        load_sel;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic        start;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        memwrite;
    logic [31:0] aluresult;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        core_run;
    logic        done;
    logic [31:0] result_word;
    logic [15:0] store_count;
    logic        err;

    modport master (
        output load_valid, load_sel, load_addr, load_data, start,
        output pc, memwrite, aluresult, writedata,
        input  load_ready, instr, readdata, core_run, done,
        input  result_word, store_count, err
    );

    modport slave (
        input  load_valid, load_sel, load_addr, load_data, start,
        input  pc, memwrite, aluresult, writedata,
        output load_ready, instr, readdata, core_run, done,
        output result_word, store_count, err
    );

endinterface

// File: rtl/mips_word_ram.sv
// Word array with one synchronous write port and one async read port.
// Contents are never reset so preloaded programs survive rst_n.
module mips_word_ram #(
    parameter int WORDS = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [WORDS];

    // Single write port; array deliberately has no reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder: instruction ROM, data RAM, load port and
// run controller (start/halt detection, store counting, error flag).
module mips_mem_responder
    import mips_pkg::*;
#(
    parameter int          IMEM_WORDS = 64,
    parameter int          DMEM_WORDS = 64,
    parameter logic [31:0] HALT_ADDR  = 32'h0000_00FC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mips_mem_responder_if.slave  bus
);

    localparam int          IAW     = idx_w(IMEM_WORDS);
    localparam int          DAW     = idx_w(DMEM_WORDS);
    localparam logic [31:0] IBYTES  = 32'(IMEM_WORDS * WORD_BYTES);
    localparam logic [31:0] DBYTES  = 32'(DMEM_WORDS * WORD_BYTES);
    localparam logic [8:0]  IWORDS9 = 9'(IMEM_WORDS);
    localparam logic [8:0]  DWORDS9 = 9'(DMEM_WORDS);

    resp_state_t r_state;
    logic        r_load_ready;
    logic        r_core_run;
    logic        r_done;
    logic [31:0] r_result;
    logic [15:0] r_count;
    logic        r_err;

    logic          w_idle;
    logic          w_run;
    logic          w_ld_go;
    logic          w_ld_imem_ok;
    logic          w_ld_dmem_ok;
    logic          w_ld_ok;
    logic          w_fetch_ok;
    logic          w_rd_ok;
    logic          w_halt_st;
    logic          w_st;
    logic          w_st_ok;
    logic          w_st_bad;
    logic          w_imem_we;
    logic          w_dmem_we;
    logic [DAW-1:0] w_dmem_waddr;
    logic [31:0]   w_dmem_wdata;
    logic [31:0]   w_imem_rd;
    logic [31:0]   w_dmem_rd;

    assign w_idle = (r_state == IDLE);
    assign w_run  = (r_state == RUN);

    assign w_ld_go      = w_idle && bus.load_valid;
    assign w_ld_imem_ok = {1'b0, bus.load_addr} < IWORDS9;
    assign w_ld_dmem_ok = {1'b0, bus.load_addr} < DWORDS9;
    assign w_ld_ok      = bus.load_sel ? w_ld_dmem_ok : w_ld_imem_ok;

    assign w_fetch_ok = (bus.pc[1:0] == 2'b00) && (bus.pc < IBYTES);
    assign w_rd_ok    = bus.aluresult < DBYTES;

    // The halt address wins over a normal store even if it maps into RAM.
    assign w_halt_st = w_run && bus.memwrite
                     && (bus.aluresult == HALT_ADDR);
    assign w_st      = w_run && bus.memwrite && !w_halt_st;
    assign w_st_ok   = w_st && (bus.aluresult[1:0] == 2'b00)
                     && (bus.aluresult < DBYTES);
    assign w_st_bad  = w_st && !w_st_ok;

    assign w_imem_we = w_ld_go && !bus.load_sel && w_ld_imem_ok;
    assign w_dmem_we = (w_ld_go && bus.load_sel && w_ld_dmem_ok)
                     || w_st_ok;

    assign w_dmem_waddr = w_st_ok ? bus.aluresult[DAW+1:2]
                                  : bus.load_addr[DAW-1:0];
    assign w_dmem_wdata = w_st_ok ? bus.writedata : bus.load_data;

    mips_word_ram #(
        .WORDS (IMEM_WORDS),
        .AW    (IAW)
    ) u_imem (
        .clk     (clk),
        .i_we    (w_imem_we),
        .i_waddr (bus.load_addr[IAW-1:0]),
        .i_wdata (bus.load_data),
        .i_raddr (bus.pc[IAW+1:2]),
        .o_rdata (w_imem_rd)
    );

    mips_word_ram #(
        .WORDS (DMEM_WORDS),
        .AW    (DAW)
    ) u_dmem (
        .clk     (clk),
        .i_we    (w_dmem_we),
        .i_waddr (w_dmem_waddr),
        .i_wdata (w_dmem_wdata),
        .i_raddr (bus.aluresult[DAW+1:2]),
        .o_rdata (w_dmem_rd)
    );

    assign bus.instr       = (w_run && w_fetch_ok) ? w_imem_rd : '0;
    assign bus.readdata    = (w_run && w_rd_ok) ? w_dmem_rd : '0;
    assign bus.load_ready  = r_load_ready;
    assign bus.core_run    = r_core_run;
    assign bus.done        = r_done;
    assign bus.result_word = r_result;
    assign bus.store_count = r_count;
    assign bus.err         = r_err;

    // Run controller: state, status outputs, store counter, error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_load_ready <= 1'b1;
            r_core_run   <= 1'b0;
            r_done       <= 1'b0;
            r_result     <= '0;
            r_count      <= '0;
            r_err        <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_ld_go && !w_ld_ok) begin
                        r_err <= 1'b1;
                    end
                    if (bus.start) begin
                        r_state      <= RUN;
                        r_load_ready <= 1'b0;
                        r_core_run   <= 1'b1;
                        r_result     <= '0;
                        r_count      <= '0;
                        r_err        <= 1'b0;
                    end
                end
                RUN: begin
                    if (!w_fetch_ok || w_st_bad) begin
                        r_err <= 1'b1;
                    end
                    if (w_halt_st) begin
                        r_state    <= HALT;
                        r_result   <= bus.writedata;
                        r_core_run <= 1'b0;
                        r_done     <= 1'b1;
                    end else if (w_st_ok && (r_count != 16'hFFFF)) begin
                        r_count <= r_count + 16'd1;
                    end
                end
                HALT: begin
                    if (bus.start) begin
                        r_state      <= IDLE;
                        r_done       <= 1'b0;
                        r_load_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_load_ready <= 1'b1;
                    r_core_run   <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

endmodule
